// File: rtl/life_pkg.sv
// Shared constants for the arena port arbiter: row index width and requester ids.
package life_pkg;

  localparam int ROW_W   = 8;
  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_LOADER = 2'd0;
  localparam logic [1:0] REQ_ENGINE = 2'd1;
  localparam logic [1:0] REQ_READER = 2'd2;

  function automatic logic [NUM_REQ-1:0] idx_to_mask(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin winner among three requesters, searching upward
// from the requester after the pointer and skipping any excluded requester.
module rr_pick3
  import life_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_ptr,
  input  logic [NUM_REQ-1:0] i_excl,
  output logic               o_valid,
  output logic [1:0]         o_idx
);

  logic [NUM_REQ-1:0] w_cand;
  logic [1:0]         w_first;
  logic [1:0]         w_second;
  logic [1:0]         w_third;

  assign w_cand = i_req & ~i_excl;

  always_comb begin
    case (i_ptr)
      2'd0: begin
        w_first  = 2'd1;
        w_second = 2'd2;
        w_third  = 2'd0;
      end
      2'd1: begin
        w_first  = 2'd2;
        w_second = 2'd0;
        w_third  = 2'd1;
      end
      default: begin
        w_first  = 2'd0;
        w_second = 2'd1;
        w_third  = 2'd2;
      end
    endcase
  end

  always_comb begin
    o_valid = 1'b1;
    o_idx   = w_third;
    if (w_cand[w_first]) begin
      o_idx = w_first;
    end else if (w_cand[w_second]) begin
      o_idx = w_second;
    end else if (w_cand[w_third]) begin
      o_idx = w_third;
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule

// File: rtl/arena_port_arbiter.sv
// Shares arena port B between loader, engine and cell reader with round-robin
// ownership, owner lock for atomic sequences and a burst limit against starvation.
module arena_port_arbiter
  import life_pkg::*;
#(
  parameter int ARENA_WIDTH  = 10,
  parameter int ARENA_HEIGHT = 10,
  parameter int MAX_BURST    = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             lock,
  input  logic [NUM_REQ*ROW_W-1:0]       row_in,
  input  logic [NUM_REQ-1:0]             we_in,
  input  logic [NUM_REQ*ARENA_WIDTH-1:0] wdata_in,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [ARENA_WIDTH-1:0]         rdata,
  output logic [NUM_REQ-1:0]             row_err,
  output logic [ROW_W-1:0]               arena_row,
  output logic [ARENA_WIDTH-1:0]         arena_columns_in,
  output logic                           arena_write,
  input  logic [ARENA_WIDTH-1:0]         arena_columns
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  localparam int               BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]    LIMIT     = BW'(MAX_BURST);
  localparam logic [BW-1:0]    LIMIT_M1  = BW'(MAX_BURST - 1);
  localparam logic [ROW_W-1:0] HEIGHT_L  = ROW_W'(ARENA_HEIGHT);

  logic [0:0]         r_state;
  logic [1:0]         r_owner;
  logic [NUM_REQ-1:0] r_gnt;
  logic [1:0]         r_ptr;
  logic [BW-1:0]      r_burst;
  logic [NUM_REQ-1:0] r_rvalid;
  logic [NUM_REQ-1:0] r_row_err;

  logic                   w_owned;
  logic [NUM_REQ-1:0]     w_own_mask;
  logic                   w_own_req;
  logic                   w_own_lock;
  logic                   w_own_we;
  logic [ROW_W-1:0]       w_own_row;
  logic [ARENA_WIDTH-1:0] w_own_wdata;
  logic                   w_row_ok;
  logic                   w_access;
  logic                   w_others;
  logic                   w_release;
  logic                   w_at_limit;
  logic                   w_force;
  logic                   w_arb;
  logic [NUM_REQ-1:0]     w_excl;
  logic                   w_pick_valid;
  logic [1:0]             w_pick_idx;

  assign w_owned     = (r_state == ST_OWNED);
  assign w_own_mask  = w_owned ? idx_to_mask(r_owner) : '0;
  assign w_own_req   = w_owned & req[r_owner];
  assign w_own_lock  = w_owned & lock[r_owner];
  assign w_own_we    = we_in[r_owner];
  assign w_own_row   = row_in[int'(r_owner)*ROW_W +: ROW_W];
  assign w_own_wdata = wdata_in[int'(r_owner)*ARENA_WIDTH +: ARENA_WIDTH];
  assign w_row_ok    = (w_own_row < HEIGHT_L);
  assign w_access    = w_own_req & w_row_ok;
  assign w_others    = |(req & ~w_own_mask);

  // The limit counts the access happening this cycle, so an owner gets exactly
  // MAX_BURST accesses before a waiting requester takes over with no bubble.
  assign w_at_limit = (r_burst == LIMIT) || (w_access && (r_burst == LIMIT_M1));
  assign w_force    = w_owned & ~w_own_lock & w_at_limit & w_others;
  assign w_release  = w_owned & ~w_own_req & ~w_own_lock;
  assign w_arb      = ~w_owned | w_release | w_force;
  assign w_excl     = w_force ? w_own_mask : '0;

  rr_pick3 u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .i_excl  (w_excl),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_owner <= REQ_LOADER;
      r_gnt   <= '0;
      r_ptr   <= REQ_READER;
      r_burst <= '0;
    end else if (w_arb) begin
      r_burst <= '0;
      if (w_pick_valid) begin
        r_state <= ST_OWNED;
        r_owner <= w_pick_idx;
        r_gnt   <= idx_to_mask(w_pick_idx);
        r_ptr   <= w_pick_idx;
      end else begin
        r_state <= ST_IDLE;
        r_gnt   <= '0;
      end
    end else if (w_own_lock) begin
      r_burst <= '0;
    end else if (w_access && (r_burst != LIMIT)) begin
      r_burst <= r_burst + 1'b1;
    end
  end

  // The issuer tag travels with the read so rvalid reaches it even after a handover.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid  <= '0;
      r_row_err <= '0;
    end else begin
      r_rvalid  <= (w_access && !w_own_we) ? w_own_mask : '0;
      r_row_err <= (w_own_req && !w_row_ok) ? w_own_mask : '0;
    end
  end

  assign gnt              = r_gnt;
  assign rvalid           = r_rvalid;
  assign rdata            = arena_columns;
  assign row_err          = r_row_err;
  assign arena_row        = w_access ? w_own_row : '0;
  assign arena_columns_in = w_access ? w_own_wdata : '0;
  assign arena_write      = w_access & w_own_we;

endmodule

// File: tb/tb_arena_port_arbiter.sv
// Self-checking bench for arena_port_arbiter: a write-first arena model on port B
// plus a requester-level reference model of ownership, reads and row errors.
module tb_arena_port_arbiter;

  localparam int W    = 10;
  localparam int H    = 10;
  localparam int MAXB = 4;

  logic          clk;
  logic          reset_n;
  logic [2:0]    req;
  logic [2:0]    lock;
  logic [23:0]   row_in;
  logic [2:0]    we_in;
  logic [3*W-1:0] wdata_in;
  logic [2:0]    gnt;
  logic [2:0]    rvalid;
  logic [W-1:0]  rdata;
  logic [2:0]    row_err;
  logic [7:0]    arena_row;
  logic [W-1:0]  arena_columns_in;
  logic          arena_write;
  logic [W-1:0]  arena_columns;

  int checks = 0;
  int errors = 0;

  arena_port_arbiter #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H), .MAX_BURST(MAXB)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req              (req),
    .lock             (lock),
    .row_in           (row_in),
    .we_in            (we_in),
    .wdata_in         (wdata_in),
    .gnt              (gnt),
    .rvalid           (rvalid),
    .rdata            (rdata),
    .row_err          (row_err),
    .arena_row        (arena_row),
    .arena_columns_in (arena_columns_in),
    .arena_write      (arena_write),
    .arena_columns    (arena_columns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arena port B as seen by the DUT: synchronous, write-first.
  logic [W-1:0] arena_mem [0:H-1];
  always @(posedge clk) begin
    if (arena_write && arena_row < H) begin
      arena_mem[arena_row] <= arena_columns_in;
      arena_columns        <= arena_columns_in;
    end else if (arena_row < H) begin
      arena_columns <= arena_mem[arena_row];
    end else begin
      arena_columns <= '0;
    end
  end

  // Reference model: owner as an integer (-1 = nobody), pointer, burst tally.
  int           m_owner;
  int           m_ptr;
  int           m_burst;
  logic [2:0]   m_rv;
  logic [2:0]   m_re;
  logic [W-1:0] m_rdata;
  logic [W-1:0] ref_mem [0:H-1];

  function automatic int row_of(input int i);
    return int'(row_in[8*i +: 8]);
  endfunction

  function automatic logic [W-1:0] wdata_of(input int i);
    return wdata_in[W*i +: W];
  endfunction

  function automatic bit f_access();
    if (m_owner < 0) return 1'b0;
    return req[m_owner] && (row_of(m_owner) < H);
  endfunction

  function automatic logic [2:0] exp_gnt();
    if (m_owner < 0) return 3'b000;
    return 3'(1 << m_owner);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int  o;
    int  win;
    int  c;
    bit  acc;
    bit  pend;
    bit  frel;
    bit  arb;
    if (!reset_n) begin
      m_owner = -1;
      m_ptr   = 2;
      m_burst = 0;
      m_rv    = '0;
      m_re    = '0;
    end else begin
      o    = m_owner;
      acc  = f_access();
      m_rv = '0;
      m_re = '0;
      if (acc) begin
        if (we_in[o]) ref_mem[row_of(o)] = wdata_of(o);
        else begin
          m_rv[o] = 1'b1;
          m_rdata = ref_mem[row_of(o)];
        end
      end
      if (o >= 0 && req[o] && row_of(o) >= H) m_re[o] = 1'b1;
      pend = 1'b0;
      for (int i = 0; i < 3; i++) if (i != o && req[i]) pend = 1'b1;
      frel = (o >= 0) && !lock[o] && (m_burst + int'(acc) >= MAXB) && pend;
      arb  = (o < 0) || (!req[o] && !lock[o]) || frel;
      if (arb) begin
        win = -1;
        for (int k = 1; k <= 3; k++) begin
          c = (m_ptr + k) % 3;
          if (win < 0 && req[c] && !(frel && c == o)) win = c;
        end
        m_owner = win;
        if (win >= 0) m_ptr = win;
        m_burst = 0;
      end else if (lock[o]) begin
        m_burst = 0;
      end else if (acc) begin
        m_burst = (m_burst + 1 > MAXB) ? MAXB : m_burst + 1;
      end
    end
  end

  task automatic set_port(input int i, input int r, input logic [W-1:0] d);
    row_in[8*i +: 8] = 8'(r);
    wdata_in[W*i +: W] = d;
  endtask

  task automatic idle_all(input int cycles);
    @(negedge clk);
    req  = '0;
    lock = '0;
    we_in = '0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = '0; lock = '0; we_in = '0; row_in = '0; wdata_in = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 000", gnt); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 000", rvalid); end
    checks++; if (row_err !== 3'b000) begin errors++; $display("[TB] FAIL reset_row_err: got %b expected 000", row_err); end
    checks++; if (arena_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_write: got %b expected 0", arena_write); end
    checks++; if (arena_row !== 8'd0) begin errors++; $display("[TB] FAIL reset_row: got %0d expected 0", arena_row); end
    checks++; if (arena_columns_in !== '0) begin errors++; $display("[TB] FAIL reset_cols: got %h expected 0", arena_columns_in); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_loader_writes();
    int r = 0;
    int guard = 0;
    @(negedge clk);
    req = 3'b001; lock = 3'b001; we_in = 3'b001;
    set_port(0, 0, 10'(1));
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL load_pre_gnt: got %b expected 000", gnt); end
    while (r < H && guard < 30) begin
      @(negedge clk);
      set_port(0, r, 10'(1) << r);
      #1;
      checks++; if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL load_gnt row %0d: got %b expected 001", r, gnt); end
      checks++; if (arena_write !== 1'b1 || arena_row !== 8'(r)) begin
        errors++; $display("[TB] FAIL load_write row %0d: got we=%b row=%0d expected we=1 row=%0d", r, arena_write, arena_row, r);
      end
      if (f_access()) r++;
      guard++;
    end
    if (r != H) begin checks++; errors++; $display("[TB] FAIL load_timeout: got %0d writes expected %0d", r, H); end
    @(negedge clk);
    req = '0; lock = '0; we_in = '0;
    for (int i = 0; i < H; i++) begin
      checks++;
      if (arena_mem[i] !== (10'(1) << i)) begin
        errors++; $display("[TB] FAIL load_mem[%0d]: got %h expected %h", i, arena_mem[i], 10'(1) << i);
      end
    end
  endtask

  task automatic test_reader_reads();
    int  r = 0;
    int  got = 0;
    int  guard = 0;
    bit  prev_acc = 1'b0;
    int  prev_row = 0;
    req = 3'b100; we_in = 3'b000;
    set_port(2, 0, '0);
    while (got < H && guard < 40) begin
      #1;
      checks++; if (rvalid[2] !== prev_acc) begin errors++; $display("[TB] FAIL read_rvalid: got %b expected %b", rvalid[2], prev_acc); end
      if (prev_acc) begin
        got++;
        checks++;
        if (rdata !== (10'(1) << prev_row)) begin errors++; $display("[TB] FAIL read_rdata row %0d: got %h expected %h", prev_row, rdata, 10'(1) << prev_row); end
      end
      prev_acc = f_access();
      prev_row = r;
      if (prev_acc) r++;
      @(negedge clk);
      if (r < H) set_port(2, r, '0);
      else req = 3'b000;
      guard++;
    end
    if (got != H) begin checks++; errors++; $display("[TB] FAIL read_timeout: got %0d reads expected %0d", got, H); end
  endtask

  task automatic test_burst_alternate();
    logic [2:0] last = 3'b000;
    int run = 0;
    idle_all(2);
    req = 3'b110; lock = '0; we_in = '0;
    set_port(1, $urandom_range(0, H-1), '0);
    set_port(2, $urandom_range(0, H-1), '0);
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL burst_pre_gnt: got %b expected 000", gnt); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      set_port(1, $urandom_range(0, H-1), '0);
      set_port(2, $urandom_range(0, H-1), '0);
      #1;
      if (i == 0) begin
        checks++; if (gnt !== 3'b010) begin errors++; $display("[TB] FAIL burst_first: got %b expected 010", gnt); end
      end
      checks++; if (gnt !== exp_gnt()) begin errors++; $display("[TB] FAIL burst_gnt cyc %0d: got %b expected %b", i, gnt, exp_gnt()); end
      checks++; if (gnt === 3'b000) begin errors++; $display("[TB] FAIL burst_bubble cyc %0d: got %b expected nonzero", i, gnt); end
      if (i > 0 && gnt !== last) begin
        checks++; if (run != MAXB) begin errors++; $display("[TB] FAIL burst_len: got %0d expected %0d", run, MAXB); end
        run = 0;
      end
      last = gnt;
      if (f_access()) run++;
    end
  endtask

  task automatic test_lock();
    idle_all(2);
    req = 3'b010; we_in = '0;
    set_port(1, 1, '0);
    @(negedge clk);
    lock = 3'b010; req = 3'b110;
    set_port(2, 2, '0);
    #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("[TB] FAIL lock_start: got %b expected 010", gnt); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      set_port(1, $urandom_range(0, H-1), '0);
      #1;
      checks++; if (gnt !== 3'b010) begin errors++; $display("[TB] FAIL lock_hold cyc %0d: got %b expected 010", i, gnt); end
    end
    @(negedge clk);
    lock = 3'b000; req = 3'b100;
    @(negedge clk);
    #1;
    checks++; if (gnt !== 3'b100) begin errors++; $display("[TB] FAIL lock_handover: got %b expected 100", gnt); end
  endtask

  task automatic test_row_error();
    idle_all(2);
    req = 3'b001; we_in = 3'b001;
    set_port(0, H, 10'h3FF);
    @(negedge clk);
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL rowerr_gnt: got %b expected 001", gnt); end
    checks++; if (arena_write !== 1'b0) begin errors++; $display("[TB] FAIL rowerr_write: got %b expected 0", arena_write); end
    @(negedge clk);
    set_port(0, 3, 10'h155);
    #1;
    checks++; if (row_err !== 3'b001) begin errors++; $display("[TB] FAIL rowerr_pulse: got %b expected 001", row_err); end
    checks++; if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL rowerr_keep: got %b expected 001", gnt); end
    checks++; if (arena_write !== 1'b1 || arena_row !== 8'd3) begin
      errors++; $display("[TB] FAIL rowerr_next: got we=%b row=%0d expected we=1 row=3", arena_write, arena_row);
    end
    @(negedge clk);
    req = '0; we_in = '0;
    #1;
    checks++; if (row_err !== 3'b000) begin errors++; $display("[TB] FAIL rowerr_once: got %b expected 000", row_err); end
    checks++; if (arena_mem[3] !== 10'h155) begin errors++; $display("[TB] FAIL rowerr_mem: got %h expected 155", arena_mem[3]); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    idle_all(1);
    req = 3'b100; we_in = '0;
    set_port(2, $urandom_range(0, H-1), '0);
    do begin
      @(negedge clk);
      set_port(2, $urandom_range(0, H-1), '0);
      guard++;
      #1;
    end while (rvalid[2] !== 1'b1 && guard < 10);
    checks++; if (rvalid[2] !== 1'b1) begin errors++; $display("[TB] FAIL midrst_setup: got %b expected 1", rvalid[2]); end
    reset_n = 1'b0;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL midrst_gnt: got %b expected 000", gnt); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("[TB] FAIL midrst_rvalid: got %b expected 000", rvalid); end
    checks++; if (arena_write !== 1'b0) begin errors++; $display("[TB] FAIL midrst_write: got %b expected 0", arena_write); end
    @(negedge clk);
    reset_n = 1'b1;
    req = 3'b101;
    set_port(0, 0, '0);
    set_port(2, 0, '0);
    @(negedge clk);
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL midrst_tie: got %b expected 001", gnt); end
  endtask

  task automatic test_random();
    bit acc;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req   = 3'($urandom_range(0, 7));
      lock  = 3'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : 0);
      we_in = 3'($urandom_range(0, 7));
      for (int j = 0; j < 3; j++) set_port(j, $urandom_range(0, H+1), W'($urandom));
      #1;
      acc = f_access();
      checks++; if (gnt !== exp_gnt()) begin errors++; $display("[TB] FAIL rand_gnt cyc %0d: got %b expected %b", i, gnt, exp_gnt()); end
      checks++; if (rvalid !== m_rv) begin errors++; $display("[TB] FAIL rand_rvalid cyc %0d: got %b expected %b", i, rvalid, m_rv); end
      checks++; if (row_err !== m_re) begin errors++; $display("[TB] FAIL rand_row_err cyc %0d: got %b expected %b", i, row_err, m_re); end
      if (m_rv != 3'b000) begin
        checks++; if (rdata !== m_rdata) begin errors++; $display("[TB] FAIL rand_rdata cyc %0d: got %h expected %h", i, rdata, m_rdata); end
      end
      checks++;
      if (arena_write !== (acc && we_in[m_owner])) begin
        errors++; $display("[TB] FAIL rand_write cyc %0d: got %b expected %b", i, arena_write, acc && we_in[m_owner]);
      end
      if (acc) begin
        checks++;
        if (arena_row !== 8'(row_of(m_owner)) || arena_columns_in !== wdata_of(m_owner)) begin
          errors++; $display("[TB] FAIL rand_drive cyc %0d: got row=%0d data=%h expected row=%0d data=%h",
                             i, arena_row, arena_columns_in, row_of(m_owner), wdata_of(m_owner));
        end
      end
    end
    idle_all(2);
  endtask

  initial begin
    reset_n  = 1'b0;
    req      = '0;
    lock     = '0;
    we_in    = '0;
    row_in   = '0;
    wdata_in = '0;
    for (int i = 0; i < H; i++) begin
      arena_mem[i] = '0;
      ref_mem[i]   = '0;
    end
    test_reset();
    test_loader_writes();
    test_reader_reads();
    test_burst_alternate();
    test_lock();
    test_row_error();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
